// File: rtl/led_zone_stats.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_zone_stats                                                             |
// | Reduces each video frame to one max(R,G,B) level per MiniLED backlight zone.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module led_zone_stats #(
  parameter int ZONE_COLS = 24,
  parameter int ZONE_ROWS = 15,
  parameter int ZONE_W    = 40,
  parameter int ZONE_H    = 48,
  parameter bit VS_POL    = 1'b1
) (
  input  logic                             I_pix_clk,
  input  logic                             I_rst,
  input  logic                             I_vs,
  input  logic                             I_de,
  input  logic [7:0]                       I_data_r,
  input  logic [7:0]                       I_data_g,
  input  logic [7:0]                       I_data_b,
  output logic [8*ZONE_COLS*ZONE_ROWS-1:0] O_led_light,
  output logic                             O_frame_done,
  output logic                             O_frame_err
);

  localparam int c_ROW_BITS = 8 * ZONE_COLS;
  localparam int c_ALL_BITS = c_ROW_BITS * ZONE_ROWS;
  localparam int c_XW = (ZONE_W > 1) ? $clog2(ZONE_W) : 1;
  localparam int c_YW = (ZONE_H > 1) ? $clog2(ZONE_H) : 1;
  localparam int c_CW = $clog2(ZONE_COLS + 1);
  localparam int c_BW = $clog2(ZONE_ROWS + 1);

  localparam logic [c_XW-1:0] c_X_LAST    = c_XW'(ZONE_W - 1);
  localparam logic [c_YW-1:0] c_Y_LAST    = c_YW'(ZONE_H - 1);
  localparam logic [c_CW-1:0] c_COL_END   = c_CW'(ZONE_COLS);
  localparam logic [c_BW-1:0] c_BAND_FULL = c_BW'(ZONE_ROWS);
  localparam logic [c_BW-1:0] c_BAND_LAST = c_BW'(ZONE_ROWS - 1);

  typedef enum logic [1:0] {
    S_WAIT_VS = 2'd0,
    S_ACC     = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t                r_state;

  // Stage 1: input register and edge history
  logic                  r_vs;
  logic                  r_vs_d;
  logic                  r_de;
  logic                  r_de_d;
  logic [7:0]            r_r;
  logic [7:0]            r_g;
  logic [7:0]            r_b;

  logic [c_XW-1:0]       r_x;
  logic [c_CW-1:0]       r_col;
  logic [c_YW-1:0]       r_y;
  logic [c_BW-1:0]       r_band;

  // Stage 2: luminance and zone column of the pixel
  logic                  r_pix_vld;
  logic [7:0]            r_pix_lum;
  logic [c_CW-1:0]       r_pix_col;
  logic                  r_commit_req;

  // Stage 3: per-column running maxima of the current band
  logic [7:0]            r_rowmax [ZONE_COLS];
  logic [c_ALL_BITS-1:0] r_shadow;

  logic                  w_vs_edge;
  logic                  w_de_fall;
  logic                  w_pix_ok;
  logic [7:0]            w_max_rg;
  logic [7:0]            w_lum;
  logic [c_ROW_BITS-1:0] w_row_flat;
  logic [c_ALL_BITS-1:0] w_shadow_next;

  assign w_vs_edge = VS_POL ? (r_vs & ~r_vs_d) : (~r_vs & r_vs_d);
  assign w_de_fall = r_de_d & ~r_de;
  assign w_pix_ok  = r_de && (r_state == S_ACC) && (r_col != c_COL_END) && !w_vs_edge;
  assign w_max_rg  = (r_r > r_g) ? r_r : r_g;
  assign w_lum     = (w_max_rg > r_b) ? w_max_rg : r_b;

  for (genvar c = 0; c < ZONE_COLS; c++) begin : g_flat
    assign w_row_flat[c*8 +: 8] = r_rowmax[c];
  end

  // Each committed band enters at the top so band 0 finishes in the lowest bits
  if (ZONE_ROWS > 1) begin : g_shift_multi
    assign w_shadow_next = {w_row_flat, r_shadow[c_ALL_BITS-1:c_ROW_BITS]};
  end else begin : g_shift_single
    assign w_shadow_next = w_row_flat;
  end

  always_ff @(posedge I_pix_clk) begin
    if (I_rst) begin
      r_vs   <= ~VS_POL;
      r_vs_d <= ~VS_POL;
      r_de   <= 1'b0;
      r_de_d <= 1'b0;
      r_r    <= 8'd0;
      r_g    <= 8'd0;
      r_b    <= 8'd0;
    end else begin
      r_vs   <= I_vs;
      r_vs_d <= r_vs;
      r_de   <= I_de;
      r_de_d <= r_de;
      r_r    <= I_data_r;
      r_g    <= I_data_g;
      r_b    <= I_data_b;
    end
  end

  // Column saturates at ZONE_COLS so overlong-line pixels drop out
  always_ff @(posedge I_pix_clk) begin
    if (I_rst || w_vs_edge) begin
      r_x   <= '0;
      r_col <= '0;
      r_y   <= '0;
    end else if (r_de) begin
      if (r_col != c_COL_END) begin
        if (r_x == c_X_LAST) begin
          r_x   <= '0;
          r_col <= r_col + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end else if (w_de_fall) begin
      r_x   <= '0;
      r_col <= '0;
      r_y   <= (r_y == c_Y_LAST) ? '0 : r_y + 1'b1;
    end
  end

  always_ff @(posedge I_pix_clk) begin
    if (I_rst || w_vs_edge) begin
      r_pix_vld    <= 1'b0;
      r_pix_lum    <= 8'd0;
      r_pix_col    <= '0;
      r_commit_req <= 1'b0;
    end else begin
      r_pix_vld    <= w_pix_ok;
      r_pix_lum    <= w_lum;
      r_pix_col    <= r_col;
      r_commit_req <= w_de_fall && (r_y == c_Y_LAST) && (r_state == S_ACC);
    end
  end

  always_ff @(posedge I_pix_clk) begin
    for (int c = 0; c < ZONE_COLS; c++) begin
      if (I_rst || w_vs_edge || r_commit_req) begin
        r_rowmax[c] <= 8'd0;
      end else if (r_pix_vld && (r_pix_col == c_CW'(c)) && (r_pix_lum > r_rowmax[c])) begin
        r_rowmax[c] <= r_pix_lum;
      end
    end
  end

  always_ff @(posedge I_pix_clk) begin
    if (I_rst) begin
      r_state      <= S_WAIT_VS;
      r_band       <= '0;
      r_shadow     <= '0;
      O_led_light  <= '0;
      O_frame_done <= 1'b0;
      O_frame_err  <= 1'b0;
    end else begin
      O_frame_done <= 1'b0;
      O_frame_err  <= 1'b0;
      if (w_vs_edge) begin
        // The first VS after reset only arms accumulation
        if (r_state != S_WAIT_VS) begin
          if (r_band == c_BAND_FULL) begin
            O_led_light  <= r_shadow;
            O_frame_done <= 1'b1;
          end else begin
            O_frame_err <= 1'b1;
          end
        end
        r_state  <= S_ACC;
        r_band   <= '0;
        r_shadow <= '0;
      end else if (r_commit_req && (r_state == S_ACC)) begin
        r_shadow <= w_shadow_next;
        r_band   <= r_band + 1'b1;
        if (r_band == c_BAND_LAST) begin
          r_state <= S_FULL;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_zone_stats.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_led_zone_stats                                                          |
// | Frame-level bench for led_zone_stats on a reduced zone grid.               |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_led_zone_stats;

  localparam int COLS = 6;
  localparam int ROWS = 4;
  localparam int ZW   = 3;
  localparam int ZH   = 2;
  localparam int NZ   = COLS * ROWS;
  localparam int AW   = COLS * ZW;
  localparam int AH   = ROWS * ZH;
  localparam int BW   = NZ * 8;

  logic          clk = 1'b0;
  logic          r_rst = 1'b1;
  logic          r_vs = 1'b0;
  logic          r_de = 1'b0;
  logic [7:0]    r_r = 8'd0;
  logic [7:0]    r_g = 8'd0;
  logic [7:0]    r_b = 8'd0;
  logic [BW-1:0] w_led;
  logic          w_done;
  logic          w_err;

  always #5 clk = ~clk;

  led_zone_stats #(
    .ZONE_COLS(COLS), .ZONE_ROWS(ROWS), .ZONE_W(ZW), .ZONE_H(ZH), .VS_POL(1'b1)
  ) dut (
    .I_pix_clk   (clk),
    .I_rst       (r_rst),
    .I_vs        (r_vs),
    .I_de        (r_de),
    .I_data_r    (r_r),
    .I_data_g    (r_g),
    .I_data_b    (r_b),
    .O_led_light (w_led),
    .O_frame_done(w_done),
    .O_frame_err (w_err)
  );

  int            n_checks = 0;
  int            n_err    = 0;
  logic [7:0]    fz [NZ];
  logic [BW-1:0] exp_led = '0;

  typedef struct {
    int mode;
    int nlines;
    int linelen;
    bit e_done;
    bit e_err;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] max3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  task automatic clear_model();
    for (int z = 0; z < NZ; z++) fz[z] = 8'd0;
  endtask

  function automatic logic [BW-1:0] model_bus();
    logic [BW-1:0] v;
    v = '0;
    for (int z = 0; z < NZ; z++) v[z*8 +: 8] = fz[z];
    return v;
  endfunction

  task automatic set_pix(input int mode, input int x, input int y);
    case (mode)
      0: begin r_r = 8'h10; r_g = 8'h80; r_b = 8'h20; end
      1: begin r_r = 8'($urandom); r_g = 8'($urandom); r_b = 8'($urandom); end
      2: begin r_r = 8'h00; r_g = 8'h00; r_b = (x == ZW + 1 && y == ZH + 1) ? 8'hC8 : 8'h00; end
      3: begin r_r = 8'h40; r_g = 8'h40; r_b = 8'h40; end
      4: begin r_r = 8'hFF; r_g = 8'hFF; r_b = 8'hFF; end
      5: begin
        r_r = (x >= AW || y >= AH) ? 8'hFF : 8'h00;
        r_g = r_r;
        r_b = r_r;
      end
      default: begin r_r = 8'h55; r_g = 8'h55; r_b = 8'h55; end
    endcase
  endtask

  task automatic model_pix(input int x, input int y);
    int z;
    if (x / ZW < COLS && y / ZH < ROWS) begin
      z = (y / ZH) * COLS + (x / ZW);
      if (max3(r_r, r_g, r_b) > fz[z]) fz[z] = max3(r_r, r_g, r_b);
    end
  endtask

  task automatic send_lines(input int mode, input int y0, input int nlines, input int linelen);
    for (int y = y0; y < y0 + nlines; y++) begin
      for (int x = 0; x < linelen; x++) begin
        r_de = 1'b1;
        set_pix(mode, x, y);
        model_pix(x, y);
        tick();
      end
      r_de = 1'b0;
      r_r = 8'($urandom);
      for (int k = 0; k < 4 + int'($urandom_range(0, 3)); k++) tick();
    end
  endtask

  task automatic do_vs(input string tag, input bit e_done, input bit e_err, input logic [BW-1:0] e_led);
    r_vs = 1'b1;
    tick();
    check({tag, "_pre"}, {w_done, w_err}, 2'b00);
    tick();
    check({tag, "_pulse"}, {w_done, w_err}, {e_done, e_err});
    check({tag, "_led"}, w_led, e_led);
    tick();
    check({tag, "_post"}, {w_done, w_err}, 2'b00);
    tick();
    r_vs = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check({tag, "_hold"}, w_led, e_led);
  endtask

  initial begin
    tbl[0] = '{mode: 0, nlines: AH,      linelen: AW,     e_done: 1'b1, e_err: 1'b0};
    tbl[1] = '{mode: 2, nlines: AH,      linelen: AW,     e_done: 1'b1, e_err: 1'b0};
    tbl[2] = '{mode: 3, nlines: AH,      linelen: AW,     e_done: 1'b1, e_err: 1'b0};
    tbl[3] = '{mode: 4, nlines: AH - 1,  linelen: AW,     e_done: 1'b0, e_err: 1'b1};
    tbl[4] = '{mode: 5, nlines: AH + 3,  linelen: AW + 4, e_done: 1'b1, e_err: 1'b0};
    tbl[5] = '{mode: 1, nlines: AH,      linelen: AW,     e_done: 1'b1, e_err: 1'b0};
    tbl[6] = '{mode: 1, nlines: AH,      linelen: AW,     e_done: 1'b1, e_err: 1'b0};
    tbl[7] = '{mode: 1, nlines: AH + 1,  linelen: AW + 1, e_done: 1'b1, e_err: 1'b0};
    tbl[8] = '{mode: 1, nlines: AH - ZH, linelen: AW,     e_done: 1'b0, e_err: 1'b1};
    tbl[9] = '{mode: 1, nlines: AH,      linelen: AW,     e_done: 1'b1, e_err: 1'b0};

    // Reset held during active video
    r_rst = 1'b1;
    r_de  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_pix(1, k, 0);
      tick();
      check("rst_led", w_led, '0);
      check("rst_pulses", {w_done, w_err}, 2'b00);
    end
    r_rst = 1'b0;
    r_de  = 1'b0;
    for (int k = 0; k < 4; k++) tick();

    // Video before the first VS is ignored and the first VS only arms
    clear_model();
    send_lines(4, 0, AH, AW);
    do_vs("arm", 1'b0, 1'b0, '0);

    for (int i = 0; i < 10; i++) begin
      clear_model();
      send_lines(tbl[i].mode, 0, tbl[i].nlines, tbl[i].linelen);
      if (tbl[i].e_done) exp_led = model_bus();
      do_vs($sformatf("vec%0d", i), tbl[i].e_done, tbl[i].e_err, exp_led);
    end

    // Reset partway through a frame
    clear_model();
    send_lines(6, 0, 3, AW);
    r_de = 1'b1;
    for (int x = 0; x < 5; x++) begin
      set_pix(6, x, 3);
      tick();
    end
    r_rst = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    r_rst = 1'b0;
    check("midrst_led", w_led, '0);
    check("midrst_pulses", {w_done, w_err}, 2'b00);
    for (int x = 8; x < AW; x++) begin
      set_pix(6, x, 3);
      tick();
    end
    r_de = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    send_lines(6, 4, AH - 4, AW);
    exp_led = '0;
    do_vs("midrst_arm", 1'b0, 1'b0, exp_led);
    clear_model();
    send_lines(6, 0, AH, AW);
    exp_led = model_bus();
    do_vs("midrst_commit", 1'b1, 1'b0, exp_led);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
